param_seq_mul: RTL and testbench
================================

PARAM_SEQ_MUL -- requirements
Module: param_seq_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand width; legal values are even integers from 4 to 64.
REQ-002 The block SHALL have one clock, clk (input, 1 bit), active on the rising edge.
REQ-003 The block SHALL have rst_n (input, 1 bit), an asynchronous active-low reset.
REQ-004 The block SHALL have start (input, 1 bit), a request to begin a multiply, sampled on the rising edge.
REQ-005 The block SHALL have is_signed (input, 1 bit): 1 selects two's-complement operands, 0 selects unsigned; it is sampled with start.
REQ-006 The block SHALL have in_A and in_B (inputs, WIDTH bits each), the multiplicand and multiplier, sampled with start.
REQ-007 The block SHALL have out_data (output, 2*WIDTH bits), the product.
REQ-008 The block SHALL have ready (output, 1 bit), high while out_data holds a valid, completed result.
REQ-009 The block SHALL have busy (output, 1 bit), high while a multiply is in progress.

Function
REQ-010 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-011 start SHALL be accepted only in IDLE or DONE; start in CALC or FIX SHALL be ignored with no side effects.
REQ-012 On an accepted start, the block SHALL:
- latch the operand magnitudes (|A| and |B| when is_signed=1, raw values otherwise);
- latch result sign = is_signed & (A[MSB] ^ B[MSB]);
- clear the count, clear ready, set busy, and go to CALC.
REQ-013 CALC SHALL perform one radix-2 add-shift step per cycle for exactly WIDTH cycles, using a (WIDTH+1)-bit adder so the carry is kept, then go to FIX.
REQ-014 FIX SHALL take one cycle: it loads out_data with the product, two's-complement negated if the latched sign is set, sets ready, clears busy, and goes to DONE.
REQ-015 Latency SHALL be fixed: ready rises on the (WIDTH+1)th rising edge after the edge that accepted start (33 for WIDTH=32), regardless of operand values.
REQ-016 In DONE, out_data and ready SHALL hold until the next accepted start; that start clears ready in the same edge.
REQ-017 out_data SHALL keep the previous result during CALC and FIX; it changes only in FIX.
REQ-018 The magnitude of the most-negative operand (-2^(WIDTH-1)) SHALL be taken as the unsigned value 2^(WIDTH-1), with no overflow.
REQ-019 busy and ready SHALL never be high at the same time.
REQ-020 The count width SHALL be clog2(WIDTH)+1; count SHALL not wrap within an operation.

Reset
REQ-021 On rst_n low, immediately and independent of clk:
- state = IDLE;
- out_data = 0, ready = 0, busy = 0;
- count, the operand registers and the sign register = 0.
REQ-022 Reset asserted mid-operation SHALL abandon the operation; no partial result SHALL ever appear on out_data.
REQ-023 The first start after reset release SHALL be accepted normally.

Structure
REQ-024 A shared package SHALL hold:
- the state enum (IDLE, CALC, FIX, DONE);
- the count-width function clog2(WIDTH)+1;
- the default WIDTH constant.
REQ-025 The single-cycle combinational datapath (conditional add of the multiplicand to the upper half, then a 1-bit right shift of the (2*WIDTH+1)-bit value) SHALL be one sub-module, mul_add_shift_step, parametrised by WIDTH.
REQ-026 The FSM, count and registers SHALL stay in param_seq_mul.

Verification
REQ-027 WIDTH=32, unsigned, A=B=0xFFFFFFFF -> out_data=0xFFFFFFFE00000001, ready high exactly 33 edges after start.
REQ-028 WIDTH=32, signed, A=7, B=0xFFFFFFFD (-3) -> out_data=0xFFFFFFFFFFFFFFEB; signed A=B=0x80000000 -> out_data=0x4000000000000000.
REQ-029 WIDTH=8, signed, A=B=0x80 -> out_data=0x4000; unsigned, A=B=0x80 -> out_data=0x4000; signed, A=0xFF, B=0x01 -> out_data=0xFFFF.
REQ-030 A second start pulsed at cycle 10 of a run (A=3, B=5) -> ignored; the original product appears at cycle 33 and busy never drops early.
REQ-031 rst_n pulsed low at cycle 12 of a run -> out_data=0, ready=0, busy=0 immediately; the next start (A=2, B=3) -> out_data=6 after 33 edges.
REQ-032 Back-to-back: start in the first DONE cycle -> ready drops on that edge, the old out_data holds until the new FIX, and the new result is correct.

Source files
------------

// File: rtl/param_seq_mul_pkg.sv
// Shared types and constants for the sequential add-shift multiplier.
// Holds the FSM state encoding, the default operand width and the counter sizing helper.
package param_seq_mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // One extra bit so the count can reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_add_shift_step.sv
// One radix-2 add-shift step of an unsigned sequential multiplier.
// Upper half accumulates partial sums; lower half holds the remaining multiplier bits.
module mul_add_shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   mcand_i,
    output logic [2*WIDTH-1:0] prod_o
);

    logic [WIDTH:0]   sum_d;
    logic [2*WIDTH:0] wide_d;

    // The carry out of the add lands in bit 2*WIDTH and is shifted back into range.
    always_comb begin
        sum_d = {1'b0, prod_i[2*WIDTH-1:WIDTH]};
        if (prod_i[0]) begin
            sum_d = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};
        end
        wide_d = {sum_d, prod_i[WIDTH-1:0]};
        prod_o = wide_d[2*WIDTH:1];
    end

endmodule

// File: rtl/param_seq_mul.sv
// Sequential WIDTH x WIDTH multiplier, signed or unsigned, with fixed WIDTH+1 cycle latency.
// Operands are converted to magnitudes, multiplied by add-shift, and the sign is applied in FIX.
module param_seq_mul
    import param_seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic [2*WIDTH-1:0]   out_data,
    output logic                 ready,
    output logic                 busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0]      LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic [CW-1:0]        count_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 sign_q;
    logic [2*WIDTH-1:0]   out_data_q;
    logic                 ready_q;
    logic                 busy_q;

    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [2*WIDTH-1:0]   prod_neg_d;

    // Negating -2^(WIDTH-1) yields the same bit pattern, which read unsigned is the correct magnitude.
    assign mag_a_d    = (is_signed && in_A[WIDTH-1]) ? (~in_A + ONE_W) : in_A;
    assign mag_b_d    = (is_signed && in_B[WIDTH-1]) ? (~in_B + ONE_W) : in_B;
    assign prod_neg_d = ~prod_q + ONE_2W;

    mul_add_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prod_i  (prod_q),
        .mcand_i (mcand_q),
        .prod_o  (prod_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            sign_q     <= 1'b0;
            out_data_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q <= mag_a_d;
                        prod_q  <= {{WIDTH{1'b0}}, mag_b_d};
                        sign_q  <= is_signed & (in_A[WIDTH-1] ^ in_B[WIDTH-1]);
                        count_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    prod_q  <= prod_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    out_data_q <= sign_q ? prod_neg_d : prod_q;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data = out_data_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_param_seq_mul.sv
// Scoreboard bench for param_seq_mul at WIDTH=32 and WIDTH=8 with directed vectors.
// Drivers push expected products; per-instance monitors pop and compare on each ready rise.
module tb_param_seq_mul;

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errs = 0;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] out32;
    logic        rdy32, bsy32, rdy32_d;
    logic [63:0] last32 = '0;
    exp_t        q32[$];

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] out8;
    logic        rdy8, bsy8, rdy8_d;
    logic [63:0] last8 = '0;
    exp_t        q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_seq_mul #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sgn32),
        .in_A(a32), .in_B(b32), .out_data(out32), .ready(rdy32), .busy(bsy32)
    );

    param_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
        .in_A(a8), .in_B(b8), .out_data(out8), .ready(rdy8), .busy(bsy8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (!rst_n) begin
            rdy32_d <= 1'b0;
        end else begin
            if (rdy32 && !rdy32_d) begin
                if (q32.size() == 0) begin
                    chk("w32 unexpected ready", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    chk("w32 product", out32, e.data);
                    chk("w32 latency", 64'(cyc - e.acc), 64'd33);
                    $display("w32 result %h latency %0d", out32, cyc - e.acc);
                    last32 = e.data;
                end
            end
            if (bsy32) chk("w32 out hold while busy", out32, last32);
            if (bsy32 && rdy32) chk("w32 busy&ready", 64'd1, 64'd0);
            rdy32_d <= rdy32;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rdy8_d <= 1'b0;
        end else begin
            if (rdy8 && !rdy8_d) begin
                if (q8.size() == 0) begin
                    chk("w8 unexpected ready", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("w8 product", {48'd0, out8}, e.data);
                    chk("w8 latency", 64'(cyc - e.acc), 64'd9);
                    $display("w8 result %h latency %0d", out8, cyc - e.acc);
                    last8 = e.data;
                end
            end
            if (bsy8) chk("w8 out hold while busy", {48'd0, out8}, last8);
            if (bsy8 && rdy8) chk("w8 busy&ready", 64'd1, 64'd0);
            rdy8_d <= rdy8;
        end
    end

    // Caller must be at a negedge; returns at the negedge after the accepting edge.
    task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit push);
        exp_t e;
        start32 = 1'b1; sgn32 = s; a32 = a; b32 = b;
        e.data = exp; e.acc = cyc + 1;
        if (push) q32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [63:0] exp);
        exp_t e;
        start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
        e.data = exp; e.acc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait32;
        for (int i = 0; i < 60; i++) begin
            if (rdy32) return;
            @(negedge clk);
        end
        chk("w32 ready timeout", 64'd0, 64'd1);
        q32.delete();
    endtask

    task automatic wait8;
        for (int i = 0; i < 30; i++) begin
            if (rdy8) return;
            @(negedge clk);
        end
        chk("w8 ready timeout", 64'd0, 64'd1);
        q8.delete();
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec32_t;

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec8_t;

    vec32_t v32[8];
    vec8_t  v8[4];

    initial begin
        v32[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        v32[1] = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB};
        v32[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        v32[3] = '{1'b0, 32'h00000003, 32'h00000005, 64'h000000000000000F};
        v32[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        v32[5] = '{1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000};
        v32[6] = '{1'b1, 32'h00000000, 32'h80000000, 64'h0000000000000000};
        v32[7] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000};
        v8[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        v8[1]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        v8[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        v8[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};

        repeat (3) @(negedge clk);
        chk("reset out_data", out32, 64'd0);
        chk("reset ready", {63'd0, rdy32}, 64'd0);
        chk("reset busy", {63'd0, bsy32}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue32(v32[i].s, v32[i].a, v32[i].b, v32[i].p, 1'b1);
            wait32();
            @(negedge clk);
        end

        // Start during CALC must be ignored.
        issue32(1'b0, 32'd2, 32'd9, 64'd18, 1'b1);
        repeat (9) @(negedge clk);
        issue32(1'b0, 32'd3, 32'd5, 64'd15, 1'b0);
        wait32();
        @(negedge clk);

        // Back-to-back: restart in the first DONE cycle.
        issue32(1'b0, 32'd11, 32'd13, 64'd143, 1'b1);
        wait32();
        issue32(1'b1, 32'hFFFFFFF6, 32'd4, 64'hFFFFFFFFFFFFFFD8, 1'b1);
        chk("b2b ready dropped", {63'd0, rdy32}, 64'd0);
        chk("b2b old data held", out32, 64'd143);
        wait32();
        @(negedge clk);

        // Asynchronous reset mid-operation.
        issue32(1'b0, 32'h12345678, 32'h9ABCDEF0, 64'd0, 1'b0);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_data", out32, 64'd0);
        chk("midrst ready", {63'd0, rdy32}, 64'd0);
        chk("midrst busy", {63'd0, bsy32}, 64'd0);
        last32 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue32(1'b0, 32'd2, 32'd3, 64'd6, 1'b1);
        wait32();
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            issue8(v8[i].s, v8[i].a, v8[i].b, {48'd0, v8[i].p});
            wait8();
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("w32 queue drained", 64'(q32.size()), 64'd0);
        chk("w8 queue drained", 64'(q8.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
